// File: rtl/ula_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ula_arbiter_pkg
// Purpose  : Shared ALU widths, opcodes and arbiter state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package ula_arbiter_pkg;

    localparam int ULA_DATA_WIDTH   = 16;
    localparam int ULA_OPCODE_WIDTH = 4;
    localparam int ULA_RFLAGS_WIDTH = 5;

    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_ADD = 4'd0;
    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_SUB = 4'd1;
    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_MUL = 4'd2;
    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_DIV = 4'd3;
    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_CMP = 4'd4;
    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_AND = 4'd5;
    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_OR  = 4'd6;
    localparam logic [ULA_OPCODE_WIDTH-1:0] OP_NOT = 4'd7;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    function automatic logic is_muldiv(input logic [ULA_OPCODE_WIDTH-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ula_arbiter
// Purpose  : Two-port valid/ready arbiter sharing one combinational ALU.
//            Define ULA_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
module ula_arbiter
    import ula_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = ULA_DATA_WIDTH,
    parameter int OPCODE_WIDTH = ULA_OPCODE_WIDTH,
    parameter int RFLAGS_WIDTH = ULA_RFLAGS_WIDTH,
    parameter int MULDIV_LAT   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [OPCODE_WIDTH-1:0] req0_opcode,
    input  logic [DATA_WIDTH-1:0]   req0_data1,
    input  logic [DATA_WIDTH-1:0]   req0_data2,
    output logic                    rsp0_valid,
    output logic [DATA_WIDTH-1:0]   rsp0_out,
    output logic [RFLAGS_WIDTH-1:0] rsp0_rflags,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [OPCODE_WIDTH-1:0] req1_opcode,
    input  logic [DATA_WIDTH-1:0]   req1_data1,
    input  logic [DATA_WIDTH-1:0]   req1_data2,
    output logic                    rsp1_valid,
    output logic [DATA_WIDTH-1:0]   rsp1_out,
    output logic [RFLAGS_WIDTH-1:0] rsp1_rflags,
    output logic [OPCODE_WIDTH-1:0] ula_opcode,
    output logic [DATA_WIDTH-1:0]   ula_data1,
    output logic [DATA_WIDTH-1:0]   ula_data2,
    input  logic [DATA_WIDTH-1:0]   ula_out,
    input  logic [RFLAGS_WIDTH-1:0] ula_rflags
);

    localparam int                 c_CNT_W  = 4;
    localparam logic [c_CNT_W-1:0] c_MD_CNT = c_CNT_W'(MULDIV_LAT - 1);

    arb_state_t                r_state, w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                      r_gnt;
    logic                      w_grant;
    logic                      w_accept;
    logic                      w_capture;
    logic [OPCODE_WIDTH-1:0]   w_sel_opcode;
    logic [OPCODE_WIDTH-1:0]   r_ula_opcode;
    logic [DATA_WIDTH-1:0]     r_ula_data1, r_ula_data2;
    logic                      r_rsp0_valid, r_rsp1_valid;
    logic [DATA_WIDTH-1:0]     r_rsp0_out, r_rsp1_out;
    logic [RFLAGS_WIDTH-1:0]   r_rsp0_rflags, r_rsp1_rflags;

`ifdef ULA_ARB_FIXED_PRIO_EN
    // req0 wins whenever it is valid
    assign w_grant = ~req0_valid;
`else
    logic r_last_grant;

    always_comb begin
        w_grant = ~req0_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    assign req0_ready   = (r_state == ARB_IDLE) && req0_valid && !w_grant;
    assign req1_ready   = (r_state == ARB_IDLE) && req1_valid &&  w_grant;
    assign w_accept     = req0_ready || req1_ready;
    assign w_sel_opcode = w_grant ? req1_opcode : req0_opcode;
    // Result is sampled on the last EXEC cycle so it is visible during DONE
    assign w_capture    = (r_state == ARB_EXEC) && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ARB_EXEC;
                    w_cnt_nxt   = is_muldiv(w_sel_opcode) ? c_MD_CNT : '0;
                end
            end
            ARB_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ARB_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ARB_DONE: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt         <= 1'b0;
            r_ula_opcode  <= '0;
            r_ula_data1   <= '0;
            r_ula_data2   <= '0;
            r_rsp0_valid  <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp0_out    <= '0;
            r_rsp1_out    <= '0;
            r_rsp0_rflags <= '0;
            r_rsp1_rflags <= '0;
        end else begin
            if (w_accept) begin
                r_gnt        <= w_grant;
                r_ula_opcode <= w_sel_opcode;
                r_ula_data1  <= w_grant ? req1_data1 : req0_data1;
                r_ula_data2  <= w_grant ? req1_data2 : req0_data2;
            end
            r_rsp0_valid <= w_capture && !r_gnt;
            r_rsp1_valid <= w_capture &&  r_gnt;
            if (w_capture && !r_gnt) begin
                r_rsp0_out    <= ula_out;
                r_rsp0_rflags <= ula_rflags;
            end
            if (w_capture && r_gnt) begin
                r_rsp1_out    <= ula_out;
                r_rsp1_rflags <= ula_rflags;
            end
        end
    end

    assign ula_opcode  = r_ula_opcode;
    assign ula_data1   = r_ula_data1;
    assign ula_data2   = r_ula_data2;
    assign rsp0_valid  = r_rsp0_valid;
    assign rsp1_valid  = r_rsp1_valid;
    assign rsp0_out    = r_rsp0_out;
    assign rsp1_out    = r_rsp1_out;
    assign rsp0_rflags = r_rsp0_rflags;
    assign rsp1_rflags = r_rsp1_rflags;

endmodule
`default_nettype wire

// File: tb/tb_ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_arbiter
// Purpose  : Self-checking bench for ula_arbiter with a behavioural ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_arbiter;
    import ula_arbiter_pkg::*;

    localparam int MULDIV_LAT = 3;
    localparam int c_LAT_MD   = 1 + MULDIV_LAT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_opcode = '0, req1_opcode = '0;
    logic [15:0] req0_data1 = '0, req0_data2 = '0, req1_data1 = '0, req1_data2 = '0;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_out, rsp1_out;
    logic [4:0]  rsp0_rflags, rsp1_rflags;
    logic [3:0]  ula_opcode;
    logic [15:0] ula_data1, ula_data2;
    logic [15:0] ula_out;
    logic [4:0]  ula_rflags;

    ula_arbiter #(.MULDIV_LAT(MULDIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_data1(req0_data1), .req0_data2(req0_data2),
        .rsp0_valid(rsp0_valid), .rsp0_out(rsp0_out), .rsp0_rflags(rsp0_rflags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_data1(req1_data1), .req1_data2(req1_data2),
        .rsp1_valid(rsp1_valid), .rsp1_out(rsp1_out), .rsp1_rflags(rsp1_rflags),
        .ula_opcode(ula_opcode), .ula_data1(ula_data1), .ula_data2(ula_data2),
        .ula_out(ula_out), .ula_rflags(ula_rflags)
    );

    always #5 clk = ~clk;

    // ALU model: flags {ovf, -, zero, -, div0}
    always_comb begin
        logic signed [15:0] a, b;
        logic signed [31:0] p;
        a = ula_data1;
        b = ula_data2;
        p = '0;
        ula_out = '0;
        ula_rflags = '0;
        case (ula_opcode)
            OP_ADD: begin
                ula_out = a + b;
                ula_rflags[4] = (a[15] == b[15]) && (ula_out[15] != a[15]);
            end
            OP_SUB: begin
                ula_out = a - b;
                ula_rflags[4] = (a[15] != b[15]) && (ula_out[15] != a[15]);
            end
            OP_MUL: begin
                p = a * b;
                ula_out = p[15:0];
            end
            OP_DIV: begin
                if (b == 16'sd0) begin
                    ula_out = a;
                    ula_rflags[0] = 1'b1;
                end else begin
                    ula_out = a / b;
                end
            end
            OP_CMP: ula_out = a - b;
            OP_AND: ula_out = a & b;
            OP_OR:  ula_out = a | b;
            OP_NOT: ula_out = ~a;
            default: ula_out = '0;
        endcase
        ula_rflags[2] = (ula_out == 16'd0);
    end

    typedef struct {
        logic        port;
        logic [3:0]  op;
        logic [15:0] d1, d2, eo;
        logic [4:0]  ef;
        int          lat;
    } vec_t;

    typedef struct {
        logic        port;
        logic [15:0] eo;
        logic [4:0]  ef;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        fly_q[$];
    int          due_q[$];
    int          acc_cyc_q[$];
    logic [15:0] last_out[2];
    int          tests = 0, fails = 0;
    int          cyc = 0, n_acc = 0, n_rsp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: accepts bind the next expected entry, responses pop and compare
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready || req1_ready) begin
                n_acc++;
                acc_cyc_q.push_back(cyc);
                chk("single_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    timeout("unexpected_accept");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("grant_port", {31'd0, req1_ready}, {31'd0, e.port});
                    fly_q.push_back(e);
                    due_q.push_back(cyc + e.lat);
                end
            end
            if (rsp0_valid || rsp1_valid) begin
                n_rsp++;
                chk("single_rsp", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
                if (fly_q.size() == 0) begin
                    timeout("unexpected_rsp");
                end else begin
                    exp_t e;
                    int   due;
                    e   = fly_q.pop_front();
                    due = due_q.pop_front();
                    chk("rsp_port", {31'd0, rsp1_valid}, {31'd0, e.port});
                    chk("rsp_latency", cyc, due);
                    if (e.port) begin
                        chk("rsp1_out", {16'd0, rsp1_out}, {16'd0, e.eo});
                        chk("rsp1_rflags", {27'd0, rsp1_rflags}, {27'd0, e.ef});
                        chk("rsp0_untouched", {16'd0, rsp0_out}, {16'd0, last_out[0]});
                    end else begin
                        chk("rsp0_out", {16'd0, rsp0_out}, {16'd0, e.eo});
                        chk("rsp0_rflags", {27'd0, rsp0_rflags}, {27'd0, e.ef});
                        chk("rsp1_untouched", {16'd0, rsp1_out}, {16'd0, last_out[1]});
                    end
                    last_out[e.port] = e.eo;
                end
            end
        end
    end

    task automatic drive(input logic port, input logic [3:0] op,
                         input logic [15:0] d1, input logic [15:0] d2, input logic v);
        if (port) begin
            req1_opcode = op; req1_data1 = d1; req1_data2 = d2; req1_valid = v;
        end else begin
            req0_opcode = op; req0_data1 = d1; req0_data2 = d2; req0_valid = v;
        end
    endtask

    task automatic wait_acc(input int target);
        int t = 0;
        while (n_acc < target && t < 60) begin
            @(posedge clk); #1; t++;
        end
        if (n_acc < target) timeout("wait_accept");
    endtask

    task automatic wait_rsp(input int target);
        int t = 0;
        while (n_rsp < target && t < 60) begin
            @(posedge clk); #1; t++;
        end
        if (n_rsp < target) timeout("wait_rsp");
    endtask

    task automatic do_op(input vec_t v);
        int a0, r0;
        a0 = n_acc;
        r0 = n_rsp;
        exp_q.push_back('{v.port, v.eo, v.ef, v.lat});
        drive(v.port, v.op, v.d1, v.d2, 1'b1);
        wait_acc(a0 + 1);
        drive(v.port, v.op, v.d1, v.d2, 1'b0);
        for (int k = 0; k < v.lat; k++) begin
            @(negedge clk);
            chk("ula_opcode_held", {28'd0, ula_opcode}, {28'd0, v.op});
            chk("ula_data1_held", {16'd0, ula_data1}, {16'd0, v.d1});
            chk("ula_data2_held", {16'd0, ula_data2}, {16'd0, v.d2});
        end
        wait_rsp(r0 + 1);
        @(negedge clk);
        chk("ula_kept_after_done", {16'd0, ula_data1}, {16'd0, v.d1});
    endtask

    // Both requesters held valid; expected grant order alternates unless fixed priority
    task automatic tie(input int n);
        int a0, r0, i0;
        a0 = n_acc;
        r0 = n_rsp;
        i0 = acc_cyc_q.size();
        for (int i = 0; i < n; i++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
            exp_q.push_back('{1'b0, 16'd2, 5'd0, 2});
`else
            if (i % 2 == 0) exp_q.push_back('{1'b0, 16'd2, 5'd0, 2});
            else            exp_q.push_back('{1'b1, 16'd5, 5'd0, 2});
`endif
        end
        drive(1'b0, OP_ADD, 16'd1, 16'd1, 1'b1);
        drive(1'b1, OP_SUB, 16'd9, 16'd4, 1'b1);
        wait_acc(a0 + n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_rsp(r0 + n);
        for (int i = 1; i < n; i++) begin
            if (acc_cyc_q.size() > i0 + i)
                chk("tie_accept_spacing", acc_cyc_q[i0+i] - acc_cyc_q[i0+i-1], 32'd3);
        end
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b0, OP_ADD, 16'd7,      16'd5,      16'd12,     5'b00000, 2};
        vecs[1]  = '{1'b1, OP_MUL, 16'hFFFD,   16'd4,      16'hFFF4,   5'b00000, c_LAT_MD};
        vecs[2]  = '{1'b0, OP_CMP, 16'd3,      16'd3,      16'd0,      5'b00100, 2};
        vecs[3]  = '{1'b0, OP_ADD, 16'd32767,  16'd1,      16'h8000,   5'b10000, 2};
        vecs[4]  = '{1'b0, OP_DIV, 16'd5,      16'd0,      16'd5,      5'b00001, c_LAT_MD};
        vecs[5]  = '{1'b1, OP_AND, 16'hF0F0,   16'h0FF0,   16'h00F0,   5'b00000, 2};
        vecs[6]  = '{1'b1, OP_OR,  16'hF000,   16'h000F,   16'hF00F,   5'b00000, 2};
        vecs[7]  = '{1'b0, OP_NOT, 16'h00FF,   16'h1234,   16'hFF00,   5'b00000, 2};
        vecs[8]  = '{1'b1, OP_SUB, 16'd9,      16'd4,      16'd5,      5'b00000, 2};
        vecs[9]  = '{1'b0, 4'hF,   16'd8,      16'd8,      16'd0,      5'b00100, 2};
        vecs[10] = '{1'b1, OP_DIV, 16'hFFEC,   16'd3,      16'hFFFA,   5'b00000, c_LAT_MD};
        last_out[0] = '0;
        last_out[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ula_opcode", {28'd0, ula_opcode}, 32'd0);
        chk("reset_rsp0_out", {16'd0, rsp0_out}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) do_op(vecs[i]);

        // Abort an in-flight DIV with reset one cycle after acceptance
        begin
            int a0;
            a0 = n_acc;
            exp_q.push_back('{1'b0, 16'd14, 5'd0, c_LAT_MD});
            drive(1'b0, OP_DIV, 16'd100, 16'd7, 1'b1);
            wait_acc(a0 + 1);
            req0_valid = 1'b0;
            rst_n = 1'b0;
            fly_q.delete();
            due_q.delete();
            exp_q.delete();
            #1;
            chk("abort_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            chk("abort_ula_data1", {16'd0, ula_data1}, 32'd0);
            chk("abort_ula_opcode", {28'd0, ula_opcode}, 32'd0);
            chk("abort_rsp0_out", {16'd0, rsp0_out}, 32'd0);
            chk("abort_rsp1_out", {16'd0, rsp1_out}, 32'd0);
            chk("abort_rsp0_rflags", {27'd0, rsp0_rflags}, 32'd0);
            last_out[0] = '0;
            last_out[1] = '0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            chk("abort_no_late_rsp", n_rsp, n_rsp - (rsp0_valid ? 1 : 0));
        end

        tie(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
